// File: rtl/param_bram_writer.sv
// param_bram_writer: assembles a little-endian byte stream into 32-bit words
// and writes NUM_PARAMS of them to consecutive BRAM port-A addresses.
// Optional feature macro: PARAM_CHECKSUM_EN. When it is defined, a trailing
// 32-bit sum is received and compared after the last word, and the result is
// reported on checksum_err.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start
// S_COLLECT | accepting bytes of the current word
// S_WRITE   | one-cycle BRAM write of the assembled word
// S_CHECK   | accepting the 4 trailing checksum bytes (checksum build only)
// S_DONE    | load finished; waiting for the next start
module param_bram_writer #(
    parameter int NUM_PARAMS = 6002,
    parameter int ADDR_W     = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              bram_ena,
    output logic              bram_wea,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [31:0]       bram_din,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] word_count
`ifdef PARAM_CHECKSUM_EN
    ,
    output logic              checksum_err
`endif
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COLLECT = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
`ifdef PARAM_CHECKSUM_EN
    localparam logic [2:0] S_CHECK   = 3'd4;
`endif

    // Index of the final word; comparing against it avoids needing a wider counter.
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_PARAMS - 1);

    logic [2:0]        state_q,      state_d;
    logic [ADDR_W-1:0] word_count_q, word_count_d;
    logic [1:0]        byte_idx_q,   byte_idx_d;
    logic [31:0]       word_q,       word_d;
    logic              accept;
`ifdef PARAM_CHECKSUM_EN
    logic [31:0]       sum_q,        sum_d;
    logic              cks_err_q,    cks_err_d;
`endif

    assign accept = in_valid & in_ready;

    // Next-state logic: byte assembly, word counting and state sequencing.
    always_comb begin
        state_d      = state_q;
        word_count_d = word_count_q;
        byte_idx_d   = byte_idx_q;
        word_d       = word_q;
`ifdef PARAM_CHECKSUM_EN
        sum_d        = sum_q;
        cks_err_d    = cks_err_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d      = S_COLLECT;
                    word_count_d = '0;
                    byte_idx_d   = '0;
                    word_d       = '0;
`ifdef PARAM_CHECKSUM_EN
                    sum_d        = '0;
                    cks_err_d    = 1'b0;
`endif
                end
            end
            S_COLLECT: begin
                if (accept) begin
                    word_d[8*byte_idx_q +: 8] = in_data;
                    byte_idx_d                = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                word_count_d = word_count_q + 1'b1;
`ifdef PARAM_CHECKSUM_EN
                sum_d        = sum_q + word_q;
`endif
                if (word_count_q == LAST_IDX) begin
`ifdef PARAM_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else begin
                    state_d = S_COLLECT;
                end
            end
`ifdef PARAM_CHECKSUM_EN
            S_CHECK: begin
                // The trailer reuses the assembly register; the 4th byte is
                // compared directly so no extra cycle is needed.
                if (accept) begin
                    word_d[8*byte_idx_q +: 8] = in_data;
                    byte_idx_d                = byte_idx_q + 2'd1;
                    if (byte_idx_q == 2'd3) begin
                        state_d   = S_DONE;
                        cks_err_d = (sum_q != {in_data, word_q[23:0]});
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // State registers; reset discards any partial word and aborts a load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            word_count_q <= '0;
            byte_idx_q   <= '0;
            word_q       <= '0;
`ifdef PARAM_CHECKSUM_EN
            sum_q        <= '0;
            cks_err_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            word_count_q <= word_count_d;
            byte_idx_q   <= byte_idx_d;
            word_q       <= word_d;
`ifdef PARAM_CHECKSUM_EN
            sum_q        <= sum_d;
            cks_err_q    <= cks_err_d;
`endif
        end
    end

    // Outputs decode from state so reset clears them without waiting for a clock.
    always_comb begin
`ifdef PARAM_CHECKSUM_EN
        in_ready = (state_q == S_COLLECT) || (state_q == S_CHECK);
        busy     = (state_q == S_COLLECT) || (state_q == S_WRITE) || (state_q == S_CHECK);
`else
        in_ready = (state_q == S_COLLECT);
        busy     = (state_q == S_COLLECT) || (state_q == S_WRITE);
`endif
        bram_ena   = (state_q == S_WRITE);
        bram_wea   = (state_q == S_WRITE);
        bram_addr  = (state_q == S_WRITE) ? word_count_q : '0;
        bram_din   = (state_q == S_WRITE) ? word_q : '0;
        done       = (state_q == S_DONE);
        word_count = word_count_q;
    end

`ifdef PARAM_CHECKSUM_EN
    assign checksum_err = cks_err_q;
`endif

endmodule

// File: tb/tb_param_bram_writer.sv
// Bench for param_bram_writer: a small instance (2 words) and a default-size
// instance (6002 words), each with its own stimulus, checked against a
// byte-stream-to-word reference model.
`timescale 1ns/1ps
module tb_param_bram_writer;

    localparam int NS = 2;
    localparam int NB = 6002;
    localparam int AW = 13;
`ifdef PARAM_CHECKSUM_EN
    localparam int CK_EXTRA = 4;
`else
    localparam int CK_EXTRA = 0;
`endif

    typedef logic [7:0]  bytes_t[$];
    typedef logic [31:0] words_t[$];

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          s_start, s_valid, s_ready, s_ena, s_wea, s_busy, s_done;
    logic [7:0]    s_data;
    logic [AW-1:0] s_addr, s_wc;
    logic [31:0]   s_din;
    logic          b_start, b_valid, b_ready, b_ena, b_wea, b_busy, b_done;
    logic [7:0]    b_data;
    logic [AW-1:0] b_addr, b_wc;
    logic [31:0]   b_din;
`ifdef PARAM_CHECKSUM_EN
    logic          s_cerr, b_cerr;
`endif

    param_bram_writer #(.NUM_PARAMS(NS), .ADDR_W(AW)) u_small (
        .clk(clk), .rst(rst), .start(s_start), .in_data(s_data), .in_valid(s_valid),
        .in_ready(s_ready), .bram_ena(s_ena), .bram_wea(s_wea), .bram_addr(s_addr),
        .bram_din(s_din), .busy(s_busy), .done(s_done), .word_count(s_wc)
`ifdef PARAM_CHECKSUM_EN
        , .checksum_err(s_cerr)
`endif
    );

    param_bram_writer u_big (
        .clk(clk), .rst(rst), .start(b_start), .in_data(b_data), .in_valid(b_valid),
        .in_ready(b_ready), .bram_ena(b_ena), .bram_wea(b_wea), .bram_addr(b_addr),
        .bram_din(b_din), .busy(b_busy), .done(b_done), .word_count(b_wc)
`ifdef PARAM_CHECKSUM_EN
        , .checksum_err(b_cerr)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Write monitors: {ena, wea, addr, din} for every cycle either strobe is high.
    logic [46:0] s_wr_q[$];
    logic [46:0] b_wr_q[$];
    always @(negedge clk) begin
        if (s_ena || s_wea) s_wr_q.push_back({s_ena, s_wea, s_addr, s_din});
        if (b_ena || b_wea) b_wr_q.push_back({b_ena, b_wea, b_addr, b_din});
    end

    bytes_t b_src;

    // Reference model: every 4 consecutive stream bytes form one word, first byte lowest.
    function automatic words_t model_words(bytes_t b);
        words_t w;
        for (int k = 0; k + 3 < b.size(); k += 4)
            w.push_back({b[k+3], b[k+2], b[k+1], b[k]});
        return w;
    endfunction

    function automatic bytes_t rand_bytes(int n);
        bytes_t b;
        for (int k = 0; k < n; k++) b.push_back(8'($urandom_range(0, 255)));
        return b;
    endfunction

    // Appends the correct trailing sum when the checksum build is in use.
    function automatic bytes_t with_trailer(bytes_t b);
`ifdef PARAM_CHECKSUM_EN
        words_t w = model_words(b);
        logic [31:0] s = '0;
        for (int k = 0; k < w.size(); k++) s = s + w[k];
        for (int j = 0; j < 4; j++) b.push_back(s[8*j +: 8]);
`endif
        return b;
    endfunction

    // Runs one small-instance load. mode 0: valid held, 1: valid alternates,
    // 2: random gaps. pulse_at >= 0 drives an extra start when that many bytes are in.
    task automatic s_send(input bytes_t bytes, input int mode, input int pulse_at,
                          output int edges, output bit timeout);
        int i = 0;
        bit acc = 1'b0;
        bit v;
        bit tog = 1'b1;
        bit pulsed = 1'b0;
        edges = 0;
        timeout = 1'b0;
        @(negedge clk);
        s_start = 1'b1;
        s_valid = 1'b0;
        while (1) begin
            @(posedge clk);
            edges++;
            if (acc) i++;
            @(negedge clk);
            s_start = 1'b0;
            if (s_done) break;
            if (edges >= 2000) begin timeout = 1'b1; break; end
            if (!pulsed && pulse_at >= 0 && i == pulse_at) begin
                s_start = 1'b1;
                pulsed  = 1'b1;
            end
            if (i < bytes.size())
                v = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
            else
                v = 1'b0;
            tog     = ~tog;
            s_valid = v;
            s_data  = v ? bytes[i] : 8'h00;
            acc     = v && s_ready;
        end
        s_valid = 1'b0;
        s_start = 1'b0;
        edges   = edges - 1;
    endtask

    // Streams b_src[0..nbytes-1] into the big instance with valid held high.
    task automatic b_run(input int nbytes, input bit wait_done, output int edges, output bit timeout);
        int i = 0;
        bit acc = 1'b0;
        bit v;
        edges = 0;
        timeout = 1'b0;
        @(negedge clk);
        b_start = 1'b1;
        b_valid = 1'b0;
        while (1) begin
            @(posedge clk);
            edges++;
            if (acc) i++;
            @(negedge clk);
            b_start = 1'b0;
            if (wait_done ? b_done : (i >= nbytes)) break;
            if (edges >= 40000) begin timeout = 1'b1; break; end
            v       = (i < nbytes);
            b_valid = v;
            b_data  = v ? b_src[i] : 8'h00;
            acc     = v && b_ready;
        end
        b_valid = 1'b0;
        edges   = edges - 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({s_ready, s_ena, s_wea, s_addr, s_din, s_busy, s_done, s_wc} !== '0) begin
            n_err++;
            $display("FAIL reset_small: got rdy=%b ena=%b wea=%b addr=%0d din=%h busy=%b done=%b wc=%0d, want all 0",
                     s_ready, s_ena, s_wea, s_addr, s_din, s_busy, s_done, s_wc);
        end
        n_cmp++;
        if ({b_ready, b_ena, b_wea, b_addr, b_din, b_busy, b_done, b_wc} !== '0) begin
            n_err++;
            $display("FAIL reset_big: got rdy=%b ena=%b wea=%b addr=%0d din=%h busy=%b done=%b wc=%0d, want all 0",
                     b_ready, b_ena, b_wea, b_addr, b_din, b_busy, b_done, b_wc);
        end
`ifdef PARAM_CHECKSUM_EN
        n_cmp++;
        if (s_cerr !== 1'b0) begin n_err++; $display("FAIL reset_cerr: got %b want 0", s_cerr); end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({s_busy, s_done, s_ready} !== 3'b000) begin
            n_err++;
            $display("FAIL idle_after_reset: got busy/done/rdy=%b want 000", {s_busy, s_done, s_ready});
        end
    endtask

    task automatic test_basic();
        bytes_t d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        words_t w = model_words(d);
        int e;
        bit to;
        s_wr_q.delete();
        s_send(with_trailer(d), 0, -1, e, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL basic_timeout: done never rose"); end
        n_cmp++;
        if (s_wr_q.size() != NS) begin n_err++; $display("FAIL basic_nwrites: got %0d want %0d", s_wr_q.size(), NS); end
        for (int k = 0; k < NS && k < s_wr_q.size(); k++) begin
            n_cmp++;
            if (s_wr_q[k] !== {1'b1, 1'b1, AW'(k), w[k]}) begin
                n_err++;
                $display("FAIL basic_write%0d: got %h want %h", k, s_wr_q[k], {1'b1, 1'b1, AW'(k), w[k]});
            end
        end
        n_cmp++;
        if ({s_done, s_busy, s_wc} !== {1'b1, 1'b0, AW'(NS)}) begin
            n_err++;
            $display("FAIL basic_final: got done=%b busy=%b wc=%0d want 1 0 %0d", s_done, s_busy, s_wc, NS);
        end
        n_cmp++;
        if (e != 5 * NS + CK_EXTRA) begin n_err++; $display("FAIL basic_latency: got %0d cycles want %0d", e, 5 * NS + CK_EXTRA); end
    endtask

    task automatic test_toggle_valid();
        bytes_t d = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        words_t w = model_words(d);
        int e;
        bit to;
        s_wr_q.delete();
        s_send(with_trailer(d), 1, -1, e, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL toggle_timeout: done never rose"); end
        n_cmp++;
        if (s_wr_q.size() != NS) begin n_err++; $display("FAIL toggle_nwrites: got %0d want %0d", s_wr_q.size(), NS); end
        for (int k = 0; k < NS && k < s_wr_q.size(); k++) begin
            n_cmp++;
            if (s_wr_q[k] !== {1'b1, 1'b1, AW'(k), w[k]}) begin
                n_err++;
                $display("FAIL toggle_write%0d: got %h want %h", k, s_wr_q[k], {1'b1, 1'b1, AW'(k), w[k]});
            end
        end
        n_cmp++;
        if (s_wc !== AW'(NS)) begin n_err++; $display("FAIL toggle_wc: got %0d want %0d", s_wc, NS); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            bytes_t d = rand_bytes(4 * NS);
            words_t w = model_words(d);
            int e;
            bit to;
            s_wr_q.delete();
            s_send(with_trailer(d), 2, -1, e, to);
            n_cmp++;
            if (to) begin n_err++; $display("FAIL random%0d_timeout: done never rose", it); end
            n_cmp++;
            if (s_wr_q.size() != NS) begin n_err++; $display("FAIL random%0d_nwrites: got %0d want %0d", it, s_wr_q.size(), NS); end
            for (int k = 0; k < NS && k < s_wr_q.size(); k++) begin
                n_cmp++;
                if (s_wr_q[k] !== {1'b1, 1'b1, AW'(k), w[k]}) begin
                    n_err++;
                    $display("FAIL random%0d_write%0d: got %h want %h", it, k, s_wr_q[k], {1'b1, 1'b1, AW'(k), w[k]});
                end
            end
        end
    endtask

    task automatic test_start_ignored();
        int pulse_pts[2] = '{4, 6};
        foreach (pulse_pts[p]) begin
            bytes_t d = rand_bytes(4 * NS);
            words_t w = model_words(d);
            int e;
            bit to;
            s_wr_q.delete();
            s_send(with_trailer(d), 0, pulse_pts[p], e, to);
            n_cmp++;
            if (to) begin n_err++; $display("FAIL start_ign%0d_timeout: done never rose", p); end
            n_cmp++;
            if (e != 5 * NS + CK_EXTRA) begin n_err++; $display("FAIL start_ign%0d_latency: got %0d want %0d", p, e, 5 * NS + CK_EXTRA); end
            n_cmp++;
            if (s_wr_q.size() != NS) begin n_err++; $display("FAIL start_ign%0d_nwrites: got %0d want %0d", p, s_wr_q.size(), NS); end
            for (int k = 0; k < NS && k < s_wr_q.size(); k++) begin
                n_cmp++;
                if (s_wr_q[k] !== {1'b1, 1'b1, AW'(k), w[k]}) begin
                    n_err++;
                    $display("FAIL start_ign%0d_write%0d: got %h want %h", p, k, s_wr_q[k], {1'b1, 1'b1, AW'(k), w[k]});
                end
            end
            n_cmp++;
            if (s_wc !== AW'(NS)) begin n_err++; $display("FAIL start_ign%0d_wc: got %0d want %0d", p, s_wc, NS); end
        end
    endtask

`ifdef PARAM_CHECKSUM_EN
    task automatic test_checksum();
        bytes_t base = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        for (int it = 0; it < 4; it++) begin
            bytes_t d;
            bytes_t t;
            words_t w;
            logic [31:0] sum;
            logic [31:0] trl;
            int e;
            bit to;
            d = (it < 2) ? base : rand_bytes(8);
            case (it)
                0:       trl = 32'h0C0A0806;
                1:       trl = 32'h00000000;
                2:       trl = 32'($urandom);
                default: trl = 32'h0;
            endcase
            w   = model_words(d);
            sum = '0;
            for (int k = 0; k < w.size(); k++) sum = sum + w[k];
            if (it == 3) trl = sum;
            t = d;
            for (int j = 0; j < 4; j++) t.push_back(trl[8*j +: 8]);
            s_wr_q.delete();
            s_send(t, 0, -1, e, to);
            n_cmp++;
            if (to) begin n_err++; $display("FAIL cks%0d_timeout: done never rose", it); end
            n_cmp++;
            if (s_cerr !== (sum != trl)) begin
                n_err++;
                $display("FAIL cks%0d_err: got %b want %b (sum %h trailer %h)", it, s_cerr, (sum != trl), sum, trl);
            end
            n_cmp++;
            if (s_wr_q.size() != NS) begin n_err++; $display("FAIL cks%0d_nwrites: got %0d want %0d", it, s_wr_q.size(), NS); end
            n_cmp++;
            if (e != 5 * NS + 4) begin n_err++; $display("FAIL cks%0d_latency: got %0d want %0d", it, e, 5 * NS + 4); end
        end
    endtask
`endif

    task automatic test_reset_midload();
        words_t w;
        int e;
        bit to;
        b_src = rand_bytes(12);
        b_wr_q.delete();
        b_run(10, 1'b0, e, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL midrst_feed_timeout: bytes not accepted"); end
        n_cmp++;
        if (b_wc !== AW'(2)) begin n_err++; $display("FAIL midrst_wc_before: got %0d want 2", b_wc); end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({b_ready, b_ena, b_wea, b_addr, b_din, b_busy, b_done, b_wc} !== '0) begin
            n_err++;
            $display("FAIL midrst_immediate: rdy=%b ena=%b wea=%b addr=%0d din=%h busy=%b done=%b wc=%0d want all 0",
                     b_ready, b_ena, b_wea, b_addr, b_din, b_busy, b_done, b_wc);
        end
        @(negedge clk);
        n_cmp++;
        if ({b_ready, b_ena, b_wea, b_addr, b_din, b_busy, b_done, b_wc} !== '0) begin
            n_err++;
            $display("FAIL midrst_next_edge: rdy=%b busy=%b wc=%0d want all 0", b_ready, b_busy, b_wc);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (b_wr_q.size() != 2) begin n_err++; $display("FAIL midrst_no_extra_write: got %0d writes want 2", b_wr_q.size()); end
        b_src = rand_bytes(4);
        w = model_words(b_src);
        b_run(4, 1'b0, e, to);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (b_wr_q.size() != 3) begin
            n_err++;
            $display("FAIL midrst_reload_nwrites: got %0d want 3", b_wr_q.size());
        end else begin
            n_cmp++;
            if (b_wr_q[2] !== {1'b1, 1'b1, AW'(0), w[0]}) begin
                n_err++;
                $display("FAIL midrst_reload_write: got %h want %h", b_wr_q[2], {1'b1, 1'b1, AW'(0), w[0]});
            end
        end
        n_cmp++;
        if (b_wc !== AW'(1)) begin n_err++; $display("FAIL midrst_reload_wc: got %0d want 1", b_wc); end
    endtask

    task automatic test_full_load();
        bytes_t d;
        words_t w;
        int e;
        bit to;
        int bad = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        d = rand_bytes(4 * NB);
        w = model_words(d);
        b_src = with_trailer(d);
        b_wr_q.delete();
        b_run(b_src.size(), 1'b1, e, to);
        n_cmp++;
        if (to) begin n_err++; $display("FAIL full_timeout: done never rose"); end
        n_cmp++;
        if (e != 5 * NB + CK_EXTRA) begin n_err++; $display("FAIL full_latency: got %0d cycles want %0d", e, 5 * NB + CK_EXTRA); end
        repeat (5) @(negedge clk);
        n_cmp++;
        if (b_wr_q.size() != NB) begin n_err++; $display("FAIL full_nwrites: got %0d want %0d", b_wr_q.size(), NB); end
        for (int k = 0; k < b_wr_q.size(); k++) begin
            if (k >= NB || b_wr_q[k] !== {1'b1, 1'b1, AW'(k), w[k]}) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL full_write_data: %0d writes differ from model, want 0", bad); end
        if (b_wr_q.size() > 0) begin
            n_cmp++;
            if (b_wr_q[b_wr_q.size()-1][44:32] !== AW'(NB - 1)) begin
                n_err++;
                $display("FAIL full_last_addr: got %0d want %0d", b_wr_q[b_wr_q.size()-1][44:32], NB - 1);
            end
        end
        n_cmp++;
        if ({b_done, b_busy, b_wc} !== {1'b1, 1'b0, AW'(NB)}) begin
            n_err++;
            $display("FAIL full_final: got done=%b busy=%b wc=%0d want 1 0 %0d", b_done, b_busy, b_wc, NB);
        end
`ifdef PARAM_CHECKSUM_EN
        n_cmp++;
        if (b_cerr !== 1'b0) begin n_err++; $display("FAIL full_cks: got %b want 0", b_cerr); end
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        s_start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00;
        repeat (3) @(negedge clk);
        test_reset();
        test_basic();
        test_toggle_valid();
        test_random();
        test_start_ignored();
`ifdef PARAM_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_midload();
        test_full_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
